// File: rtl/light_tracker_ctrl.sv
// Sun-tracking controller: evaluates LDR imbalance on alternating axes and
// issues timed CCW/CW step requests to the two servo drivers.
module light_tracker_ctrl #(
  parameter int ADC_W        = 12,
  parameter int DEADBAND     = 40,
  parameter int MOVE_TICKS   = 2_000_000,
  parameter int SETTLE_TICKS = 5_000_000,
  parameter int LOCK_COUNT   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LDR_VALID,
  input  logic [ADC_W-1:0] LDR_LEFT,
  input  logic [ADC_W-1:0] LDR_RIGHT,
  input  logic [ADC_W-1:0] LDR_TOP,
  input  logic [ADC_W-1:0] LDR_BOT,
  input  logic             LIMIT_H,
  input  logic             LIMIT_V,
  output logic             H_CCW,
  output logic             H_CW,
  output logic             V_CCW,
  output logic             V_CW,
  output logic             ALIGNED,
  output logic [2:0]       STATE
);

  localparam int CNT_MAX = (MOVE_TICKS > SETTLE_TICKS) ? MOVE_TICKS : SETTLE_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LOCK_W  = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]      MOVE_LAST   = CNT_W'(MOVE_TICKS - 1);
  localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [LOCK_W-1:0]     LOCK_FULL   = LOCK_W'(LOCK_COUNT);
  localparam logic signed [ADC_W:0] DB_POS      = (ADC_W + 1)'(DEADBAND);
  localparam logic signed [ADC_W:0] DB_NEG      = -DB_POS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EVAL   = 3'd1,
    S_MOVE   = 3'd2,
    S_SETTLE = 3'd3
  } state_t;

  typedef enum logic {
    AXIS_H = 1'b0,
    AXIS_V = 1'b1
  } axis_t;

  state_t             r_state, w_state_next;
  axis_t              r_axis,  w_axis_next;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_next;
  logic [LOCK_W-1:0]  r_lock,  w_lock_next;
  logic               r_ccw,   w_ccw_next;
  logic               r_cw,    w_cw_next;
  logic [ADC_W-1:0]   r_left, r_right, r_top, r_bot;
  logic               w_latch;
  logic signed [ADC_W:0] w_diff;
  logic               w_limit_sel;
  logic               w_req_ccw;
  logic               w_req_cw;

  // One extra bit keeps full-scale differences (0 vs 2^ADC_W-1) exact.
  always_comb begin
    if (r_axis == AXIS_H)
      w_diff = $signed({1'b0, r_left}) - $signed({1'b0, r_right});
    else
      w_diff = $signed({1'b0, r_top}) - $signed({1'b0, r_bot});
  end

  assign w_limit_sel = (r_axis == AXIS_H) ? LIMIT_H : LIMIT_V;
  assign w_req_ccw   = (w_diff > DB_POS);
  assign w_req_cw    = (w_diff < DB_NEG) && !w_limit_sel;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_axis_next  = r_axis;
    w_lock_next  = r_lock;
    w_ccw_next   = r_ccw;
    w_cw_next    = r_cw;
    w_latch      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (LDR_VALID) begin
          w_latch      = 1'b1;
          w_state_next = S_EVAL;
        end
      end
      S_EVAL: begin
        w_cnt_next = '0;
        if (w_req_ccw || w_req_cw) begin
          w_state_next = S_MOVE;
          w_lock_next  = '0;
          w_ccw_next   = w_req_ccw;
          w_cw_next    = w_req_cw;
        end else begin
          w_state_next = S_IDLE;
          w_axis_next  = (r_axis == AXIS_H) ? AXIS_V : AXIS_H;
          if (r_lock != LOCK_FULL)
            w_lock_next = r_lock + LOCK_W'(1);
        end
      end
      S_MOVE: begin
        // A CW step that reaches the pulse-width limit is cut short.
        if ((r_cnt == MOVE_LAST) || (r_cw && w_limit_sel)) begin
          w_state_next = S_SETTLE;
          w_cnt_next   = '0;
          w_ccw_next   = 1'b0;
          w_cw_next    = 1'b0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_axis_next  = (r_axis == AXIS_H) ? AXIS_V : AXIS_H;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_ccw_next   = 1'b0;
        w_cw_next    = 1'b0;
      end
    endcase

    // Disable aborts from any state but keeps axis order and lock history.
    if (!EN) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_ccw_next   = 1'b0;
      w_cw_next    = 1'b0;
      w_latch      = 1'b0;
      w_axis_next  = r_axis;
      w_lock_next  = r_lock;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_axis  <= AXIS_H;
      r_cnt   <= '0;
      r_lock  <= '0;
      r_ccw   <= 1'b0;
      r_cw    <= 1'b0;
      r_left  <= '0;
      r_right <= '0;
      r_top   <= '0;
      r_bot   <= '0;
    end else begin
      r_state <= w_state_next;
      r_axis  <= w_axis_next;
      r_cnt   <= w_cnt_next;
      r_lock  <= w_lock_next;
      r_ccw   <= w_ccw_next;
      r_cw    <= w_cw_next;
      if (w_latch) begin
        r_left  <= LDR_LEFT;
        r_right <= LDR_RIGHT;
        r_top   <= LDR_TOP;
        r_bot   <= LDR_BOT;
      end
    end
  end

  assign H_CCW   = r_ccw && (r_axis == AXIS_H);
  assign H_CW    = r_cw  && (r_axis == AXIS_H);
  assign V_CCW   = r_ccw && (r_axis == AXIS_V);
  assign V_CW    = r_cw  && (r_axis == AXIS_V);
  assign ALIGNED = (r_lock == LOCK_FULL);
  assign STATE   = r_state;

endmodule

// File: tb/tb_light_tracker_ctrl.sv
// Bench for light_tracker_ctrl: directed scenarios plus randomized samples
// checked against a transaction-level model of the tracking rules.
module tb_light_tracker_ctrl;

  localparam int ADC_W = 12;
  localparam int DB    = 40;
  localparam int MT    = 8;
  localparam int ST    = 16;
  localparam int LC    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b1;
  logic             valid = 1'b0;
  logic [ADC_W-1:0] l = '0, r = '0, t = '0, b = '0;
  logic             lim_h = 1'b0, lim_v = 1'b0;
  logic             h_ccw, h_cw, v_ccw, v_cw, aligned;
  logic [2:0]       state;
  logic [3:0]       outs;

  int n_checks = 0;
  int n_errors = 0;
  int m_axis   = 0;   // 0 = horizontal, 1 = vertical
  int m_lock   = 0;

  always #5 clk = ~clk;

  assign outs = {h_ccw, h_cw, v_ccw, v_cw};

  light_tracker_ctrl #(
    .ADC_W(ADC_W), .DEADBAND(DB), .MOVE_TICKS(MT),
    .SETTLE_TICKS(ST), .LOCK_COUNT(LC)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .LDR_VALID(valid),
    .LDR_LEFT(l), .LDR_RIGHT(r), .LDR_TOP(t), .LDR_BOT(b),
    .LIMIT_H(lim_h), .LIMIT_V(lim_v),
    .H_CCW(h_ccw), .H_CW(h_cw), .V_CCW(v_ccw), .V_CW(v_cw),
    .ALIGNED(aligned), .STATE(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] dir_code(input int axis, input int dir);
    if (dir == 1) return (axis == 0) ? 4'b1000 : 4'b0010;
    if (dir == 2) return (axis == 0) ? 4'b0100 : 4'b0001;
    return 4'b0000;
  endfunction

  // Entered and left on a negedge with the DUT idle.
  task automatic run_txn(input int lv, input int rv, input int tv, input int bv,
                         input bit lh, input bit lvv);
    int d;
    int dir;
    bit lim;
    l = lv[ADC_W-1:0]; r = rv[ADC_W-1:0]; t = tv[ADC_W-1:0]; b = bv[ADC_W-1:0];
    lim_h = lh; lim_v = lvv; valid = 1'b1;
    d   = (m_axis == 0) ? lv - rv : tv - bv;
    lim = (m_axis == 0) ? lh : lvv;
    if (d > DB)                 dir = 1;
    else if (d < -DB && !lim)   dir = 2;
    else                        dir = 0;
    @(negedge clk); valid = 1'b0;
    check("eval_state", state, 1);
    check("eval_outs", outs, 0);
    check("eval_aligned", aligned, (m_lock == LC));
    if (dir != 0) begin
      m_lock = 0;
      for (int i = 0; i < MT; i++) begin
        @(negedge clk);
        check("move_state", state, 2);
        check("move_outs", outs, dir_code(m_axis, dir));
        check("move_aligned", aligned, 0);
      end
      for (int i = 0; i < ST; i++) begin
        @(negedge clk);
        check("settle_state", state, 3);
        check("settle_outs", outs, 0);
      end
      @(negedge clk);
      check("post_move_state", state, 0);
    end else begin
      if (m_lock < LC) m_lock++;
      @(negedge clk);
      check("nomove_state", state, 0);
      check("nomove_outs", outs, 0);
      check("nomove_aligned", aligned, (m_lock == LC));
    end
    m_axis ^= 1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_state", state, 0);
      check("idle_outs", outs, 0);
    end
  endtask

  initial begin
    int lv, rv, tv, bv, base, mode;
    bit lh, lvv;

    // Reset state
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_outs", outs, 0);
    check("rst_aligned", aligned, 0);
    @(negedge clk); rst = 1'b0;
    idle_cycles(10);

    // H move, then the next strobe is evaluated on V
    run_txn(1000, 900, 2000, 2000, 0, 0);
    run_txn(2000, 2000, 1000, 900, 0, 0);

    // Asynchronous reset in the middle of an H_CCW step
    l = 12'd1000; r = 12'd900; t = 12'd2000; b = 12'd2000; valid = 1'b1;
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_hccw", h_ccw, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_hccw", h_ccw, 0);
    check("async_rst_state", state, 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    m_axis = 0; m_lock = 0;
    idle_cycles(10);

    // Deadband boundary: diff 40 holds still, diff 41 moves
    run_txn(940, 900, 2000, 2000, 0, 0);
    run_txn(2000, 2000, 2000, 2000, 0, 0);
    run_txn(941, 900, 2000, 2000, 0, 0);

    // CW suppressed by an active V limit
    if (m_axis != 1) run_txn(2000, 2000, 2000, 2000, 0, 0);
    run_txn(2000, 2000, 100, 4095, 0, 1);
    run_txn(2000, 2000, 2000, 2000, 0, 0);

    // V limit rising on the third cycle of a V_CW step
    l = 12'd2000; r = 12'd2000; t = 12'd100; b = 12'd4095; lim_v = 1'b0; valid = 1'b1;
    @(negedge clk); valid = 1'b0;
    check("lim_eval_state", state, 1);
    m_lock = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lim_move_state", state, 2);
      check("lim_move_outs", outs, 4'b0001);
    end
    lim_v = 1'b1;
    @(negedge clk);
    check("lim_abort_state", state, 3);
    check("lim_abort_outs", outs, 0);
    lim_v = 1'b0;
    for (int i = 1; i < ST; i++) begin
      @(negedge clk);
      check("lim_settle_state", state, 3);
    end
    @(negedge clk);
    check("lim_post_state", state, 0);
    m_axis ^= 1;

    // Full-scale differences
    run_txn(4095, 0, 2000, 2000, 0, 0);
    run_txn(2000, 2000, 0, 4095, 0, 0);
    run_txn(0, 4095, 2000, 2000, 0, 0);

    // Lock-in with balanced samples, hold across a disable, then break lock
    for (int i = 0; i < LC; i++) run_txn(2000, 2000, 2000, 2000, 0, 0);
    check("locked_aligned", aligned, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("dis_aligned_held", aligned, 1);
      check("dis_state", state, 0);
    end
    en = 1'b1;
    @(negedge clk);
    if (m_axis != 0) run_txn(2000, 2000, 2000, 2000, 0, 0);
    run_txn(2100, 2000, 2000, 2000, 0, 0);

    // Disable during SETTLE: no axis toggle, strobes ignored while disabled
    if (m_axis != 1) run_txn(2000, 2000, 2000, 2000, 0, 0);
    l = 12'd2000; r = 12'd2000; t = 12'd1000; b = 12'd900; valid = 1'b1;
    @(negedge clk); valid = 1'b0;
    m_lock = 0;
    repeat (MT + 3) @(negedge clk);
    check("abort_pre_state", state, 3);
    en = 1'b0;
    @(negedge clk);
    check("abort_state", state, 0);
    check("abort_outs", outs, 0);
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dis_strobe_state", state, 0);
    end
    valid = 1'b0; en = 1'b1;
    @(negedge clk);
    run_txn(2000, 2000, 1000, 900, 0, 0);

    // Disable during MOVE drops the step on the next edge
    if (m_axis != 0) run_txn(2000, 2000, 2000, 2000, 0, 0);
    l = 12'd900; r = 12'd1000; t = 12'd2000; b = 12'd2000; valid = 1'b1;
    @(negedge clk); valid = 1'b0;
    m_lock = 0;
    @(negedge clk);
    check("mv_dis_pre_outs", outs, 4'b0100);
    en = 1'b0;
    @(negedge clk);
    check("mv_dis_state", state, 0);
    check("mv_dis_outs", outs, 0);
    en = 1'b1;
    @(negedge clk);

    // Randomized samples
    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        lv = $urandom_range(0, 4095); rv = $urandom_range(0, 4095);
        tv = $urandom_range(0, 4095); bv = $urandom_range(0, 4095);
      end else begin
        base = $urandom_range(100, 3900);
        lv = base + $urandom_range(0, 120) - 60; rv = base;
        tv = base; bv = base + $urandom_range(0, 120) - 60;
      end
      lh  = ($urandom_range(0, 3) == 0);
      lvv = ($urandom_range(0, 3) == 0);
      run_txn(lv, rv, tv, bv, lh, lvv);
    end
    lim_h = 1'b0; lim_v = 1'b0;
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
